mptw_pte_fetch: RTL and testbench

MPTW_PTE_FETCH -- requirements
Module: mptw_pte_fetch

---
 rtl/mptw_pkg.sv | 33 +++
 rtl/mptw_pte_fetch.sv | 190 +++++++++++++++++++
 tb/tb_mptw_pte_fetch.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mptw_pkg.sv
// Shared types for the MPT walker: the transaction carried between stages and
// the flush command/status encodings.
package mptw_pkg;

  localparam int MPTW_PADDR_WIDTH = 56;

  typedef struct packed {
    logic [7:0]                  id;
    logic [MPTW_PADDR_WIDTH-1:0] ptaddr;
    logic [1:0]                  level;
    logic                        speculative;
  } mptw_transaction_t;

  typedef enum logic [1:0] {
    MPT_FLUSH_NONE = 2'd0,
    MPT_FLUSH_ALL  = 2'd1,
    MPT_FLUSH_SPEC = 2'd2
  } mptw_flush_ctrl_e;

  typedef enum logic [0:0] {
    MPT_FLUSHED_NONE      = 1'b0,
    MPT_FLUSHED_COMPLETED = 1'b1
  } mptw_flush_status_e;

  function automatic logic [MPTW_PADDR_WIDTH-1:0] txn_ptaddr(input mptw_transaction_t t);
    return t.ptaddr;
  endfunction

  function automatic logic txn_speculative(input mptw_transaction_t t);
    return t.speculative;
  endfunction

endpackage

// File: rtl/mptw_pte_fetch.sv
// Single-outstanding MPT entry fetch stage: holds one transaction, reads its
// entry from memory and presents transaction + entry downstream; supports flush.
module mptw_pte_fetch
  import mptw_pkg::*;
#(
  parameter int DATA_WIDTH  = $bits(mptw_transaction_t),
  parameter int PTE_WIDTH   = 64,
  parameter int PADDR_WIDTH = 56
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                s_data_valid,
  output logic                                s_data_ready,
  input  logic [DATA_WIDTH-1:0]               s_data_data,
  output logic                                m_data_valid,
  input  logic                                m_data_ready,
  output logic [DATA_WIDTH-1:0]               m_data_data,
  output logic [PTE_WIDTH-1:0]                m_data_pte,
  output logic                                m_data_err,
  output logic                                mem_req_o,
  output logic [PADDR_WIDTH-1:0]              mem_addr_o,
  input  logic                                mem_gnt_i,
  input  logic                                mem_rvalid_i,
  input  logic [PTE_WIDTH-1:0]                mem_rdata_i,
  input  logic                                mem_err_i,
  input  logic [$bits(mptw_flush_ctrl_e)-1:0] s_ctrl_flush,
  output logic [$bits(mptw_flush_status_e)-1:0] m_status_flushed,
  output logic                                m_status_busy,
  output logic                                m_status_stalled
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_OUT   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e                 state_reg;
  logic [DATA_WIDTH-1:0]  held_reg;
  logic [PTE_WIDTH-1:0]   pte_reg;
  logic                   err_reg;
  logic                   m_valid_reg;
  logic                   mem_req_reg;
  logic                   busy_reg;

  logic flush_all;
  logic flush_spec;
  logic flush_hit;
  logic held_spec;

  assign held_spec  = txn_speculative(held_reg);
  assign flush_all  = (s_ctrl_flush == MPT_FLUSH_ALL);
  assign flush_spec = (s_ctrl_flush == MPT_FLUSH_SPEC) && held_spec;

  // IDLE holds nothing live, so only FLUSH_ALL matters there (it blocks capture);
  // DRAIN ignores further flushes.
  always_comb begin
    flush_hit = 1'b0;
    unique case (state_reg)
      ST_IDLE:                   flush_hit = flush_all;
      ST_REQ, ST_WAIT, ST_OUT:   flush_hit = flush_all || flush_spec;
      default:                   flush_hit = 1'b0;
    endcase
  end

  always_comb begin
    s_data_ready = 1'b0;
    if (!flush_hit) begin
      s_data_ready = (state_reg == ST_IDLE) ||
                     ((state_reg == ST_OUT) && m_data_ready);
    end
  end

  always_comb begin
    m_status_flushed = MPT_FLUSHED_NONE;
    unique case (state_reg)
      ST_IDLE, ST_OUT: if (flush_hit) m_status_flushed = MPT_FLUSHED_COMPLETED;
      ST_REQ:          if (flush_hit && !mem_gnt_i) m_status_flushed = MPT_FLUSHED_COMPLETED;
      ST_WAIT:         if (flush_hit && mem_rvalid_i) m_status_flushed = MPT_FLUSHED_COMPLETED;
      ST_DRAIN:        if (mem_rvalid_i) m_status_flushed = MPT_FLUSHED_COMPLETED;
      default:         m_status_flushed = MPT_FLUSHED_NONE;
    endcase
  end

  assign m_status_stalled = ((state_reg == ST_REQ) && !mem_gnt_i) ||
                            ((state_reg == ST_OUT) && !m_data_ready);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      held_reg    <= '0;
      pte_reg     <= '0;
      err_reg     <= 1'b0;
      m_valid_reg <= 1'b0;
      mem_req_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (!flush_hit && s_data_valid) begin
            held_reg    <= s_data_data;
            state_reg   <= ST_REQ;
            mem_req_reg <= 1'b1;
            busy_reg    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (flush_hit) begin
            held_reg    <= '0;
            pte_reg     <= '0;
            err_reg     <= 1'b0;
            mem_req_reg <= 1'b0;
            // A grant in the flush cycle means a response is still coming back.
            if (mem_gnt_i) begin
              state_reg <= ST_DRAIN;
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end else if (mem_gnt_i) begin
            state_reg   <= ST_WAIT;
            mem_req_reg <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (flush_hit) begin
            held_reg <= '0;
            pte_reg  <= '0;
            err_reg  <= 1'b0;
            // Response landing in the flush cycle is consumed here; nothing to drain.
            if (mem_rvalid_i) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= ST_DRAIN;
            end
          end else if (mem_rvalid_i) begin
            pte_reg     <= mem_rdata_i;
            err_reg     <= mem_err_i;
            state_reg   <= ST_OUT;
            m_valid_reg <= 1'b1;
          end
        end
        ST_OUT: begin
          if (flush_hit) begin
            held_reg    <= '0;
            pte_reg     <= '0;
            err_reg     <= 1'b0;
            m_valid_reg <= 1'b0;
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
          end else if (m_data_ready) begin
            m_valid_reg <= 1'b0;
            if (s_data_valid) begin
              held_reg    <= s_data_data;
              state_reg   <= ST_REQ;
              mem_req_reg <= 1'b1;
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (mem_rvalid_i) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          m_valid_reg <= 1'b0;
          mem_req_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign m_data_valid  = m_valid_reg;
  assign m_data_data   = held_reg;
  assign m_data_pte    = pte_reg;
  assign m_data_err    = err_reg;
  assign mem_req_o     = mem_req_reg;
  assign mem_addr_o    = PADDR_WIDTH'(txn_ptaddr(held_reg));
  assign m_status_busy = busy_reg;

endmodule

// File: tb/tb_mptw_pte_fetch.sv
// Directed bench for mptw_pte_fetch: a vector table of complete fetches plus
// hand sequences for flush, back-to-back and reset corner cases.
module tb_mptw_pte_fetch;
  import mptw_pkg::*;

  localparam int DW = $bits(mptw_transaction_t);
  localparam int PW = 64;
  localparam int AW = 56;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           s_data_valid;
  logic           s_data_ready;
  logic [DW-1:0]  s_data_data;
  logic           m_data_valid;
  logic           m_data_ready;
  logic [DW-1:0]  m_data_data;
  logic [PW-1:0]  m_data_pte;
  logic           m_data_err;
  logic           mem_req_o;
  logic [AW-1:0]  mem_addr_o;
  logic           mem_gnt_i;
  logic           mem_rvalid_i;
  logic [PW-1:0]  mem_rdata_i;
  logic           mem_err_i;
  logic [1:0]     s_ctrl_flush;
  logic [0:0]     m_status_flushed;
  logic           m_status_busy;
  logic           m_status_stalled;

  mptw_pte_fetch dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data_data(s_data_data),
    .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data_data(m_data_data),
    .m_data_pte(m_data_pte), .m_data_err(m_data_err),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .s_ctrl_flush(s_ctrl_flush), .m_status_flushed(m_status_flushed),
    .m_status_busy(m_status_busy), .m_status_stalled(m_status_stalled)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [55:0] ptaddr;
    logic        spec;
    logic [63:0] rdata;
    logic        rerr;
    int          gnt_dly;
    int          rv_dly;
    int          rdy_dly;
    logic [63:0] exp_pte;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] mk_txn(input logic [7:0] id, input logic [55:0] pa, input logic sp);
    mptw_transaction_t t;
    t.id = id; t.ptaddr = pa; t.level = 2'd1; t.speculative = sp;
    return t;
  endfunction

  task automatic idle_inputs();
    s_data_valid = 0; m_data_ready = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    mem_rdata_i = '0; mem_err_i = 0; s_ctrl_flush = MPT_FLUSH_NONE;
  endtask

  // Drive one transaction from IDLE to OUT with single-cycle gnt and rvalid.
  task automatic to_out(input logic [DW-1:0] txn, input logic [63:0] rd);
    s_data_valid = 1; s_data_data = txn; step(); s_data_valid = 0;
    mem_gnt_i = 1; step(); mem_gnt_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = rd; step(); mem_rvalid_i = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [DW-1:0] txn;
    int lat;
    txn = mk_txn(8'(idx), v.ptaddr, v.spec);
    s_data_valid = 1; s_data_data = txn; #1;
    chk("accept_ready", s_data_ready, 1);
    step(); s_data_valid = 0; s_data_data = '0; lat = 1;
    for (int k = 0; k < v.gnt_dly; k++) begin
      #1;
      chk("req_addr", mem_addr_o, v.ptaddr);
      chk("req_stalled", m_status_stalled, 1);
      step(); lat++;
    end
    mem_gnt_i = 1; #1;
    chk("req_on_gnt", mem_req_o, 1);
    chk("addr_on_gnt", mem_addr_o, v.ptaddr);
    chk("valid_before", m_data_valid, (lat >= v.exp_lat));
    step(); lat++; mem_gnt_i = 0;
    chk("req_dropped", mem_req_o, 0);
    for (int k = 0; k < v.rv_dly; k++) begin
      chk("wait_valid", m_data_valid, (lat >= v.exp_lat));
      step(); lat++;
    end
    mem_rvalid_i = 1; mem_rdata_i = v.rdata; mem_err_i = v.rerr;
    step(); lat++;
    mem_rvalid_i = 0; mem_rdata_i = '0; mem_err_i = 0;
    chk("out_valid_at_lat", m_data_valid, (lat >= v.exp_lat));
    for (int k = 0; k < v.rdy_dly; k++) begin
      chk("out_hold_valid", m_data_valid, 1);
      chk("out_hold_pte", m_data_pte, v.exp_pte);
      chk("out_stalled", m_status_stalled, 1);
      chk("out_s_ready", s_data_ready, 0);
      step();
    end
    m_data_ready = 1; #1;
    chk("out_pte", m_data_pte, v.exp_pte);
    chk("out_err", m_data_err, v.exp_err);
    chk("out_data", m_data_data, txn);
    chk("out_s_ready_rdy", s_data_ready, 1);
    step(); m_data_ready = 0;
    chk("back_idle_busy", m_status_busy, 0);
    chk("back_idle_valid", m_data_valid, 0);
    $display("vec %0d ptaddr=0x%0h pte=0x%0h err=%0b checks=%0d", idx, v.ptaddr, m_data_pte, m_data_err, n_checks);
  endtask

  initial begin
    vecs[0] = '{56'h1000, 1'b0, 64'hDEAD, 1'b0, 0, 0, 0, 64'hDEAD, 1'b0, 3};
    vecs[1] = '{56'h1000, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 4, 0, 0, 64'h1234_5678_9ABC_DEF0, 1'b0, 7};
    vecs[2] = '{56'h2000, 1'b1, 64'hCAFE_0001, 1'b0, 0, 2, 5, 64'hCAFE_0001, 1'b0, 5};
    vecs[3] = '{56'h3008, 1'b1, 64'h0, 1'b1, 0, 0, 0, 64'h0, 1'b1, 3};
    vecs[4] = '{56'hFF_FFFF_FFFF_FFF8, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5};

    idle_inputs(); s_data_data = '0;
    rst_i = 1; step(); step(); rst_i = 0; #1;
    chk("rst_s_ready", s_data_ready, 1);
    chk("rst_m_valid", m_data_valid, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_busy", m_status_busy, 0);
    chk("rst_stalled", m_status_stalled, 0);
    chk("rst_flushed", m_status_flushed, MPT_FLUSHED_NONE);
    chk("rst_pte", m_data_pte, 0);
    chk("rst_data", m_data_data, 0);
    $display("reset checks done: %0d", n_checks);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // FLUSH_ALL in WAIT; response two cycles later is drained silently.
    s_data_valid = 1; s_data_data = mk_txn(8'h10, 56'h4000, 1'b0); step(); s_data_valid = 0;
    mem_gnt_i = 1; step(); mem_gnt_i = 0;
    s_ctrl_flush = MPT_FLUSH_ALL; #1;
    chk("wait_flush_status", m_status_flushed, MPT_FLUSHED_NONE);
    step();
    chk("drain_s_ready", s_data_ready, 0);
    chk("drain_busy", m_status_busy, 1);
    chk("drain_flush_ignored", m_status_flushed, MPT_FLUSHED_NONE);
    s_ctrl_flush = MPT_FLUSH_NONE; step();
    chk("drain_no_valid", m_data_valid, 0);
    mem_rvalid_i = 1; mem_rdata_i = 64'hBAD; #1;
    chk("drain_completed", m_status_flushed, MPT_FLUSHED_COMPLETED);
    step(); mem_rvalid_i = 0;
    chk("drain_done_valid", m_data_valid, 0);
    chk("drain_done_idle", s_data_ready, 1);
    chk("drain_cleared", m_data_data, 0);
    $display("seq flush_all_wait done");

    // FLUSH_SPEC on a non-speculative result is ignored.
    to_out(mk_txn(8'h20, 56'h5000, 1'b0), 64'h55);
    s_ctrl_flush = MPT_FLUSH_SPEC; #1;
    chk("spec0_status", m_status_flushed, MPT_FLUSHED_NONE);
    step(); s_ctrl_flush = MPT_FLUSH_NONE;
    chk("spec0_valid", m_data_valid, 1);
    m_data_ready = 1; #1;
    chk("spec0_pte", m_data_pte, 64'h55);
    step(); m_data_ready = 0;
    $display("seq flush_spec nonspec done");

    // FLUSH_SPEC on a speculative result wins over a simultaneous handshake.
    to_out(mk_txn(8'h21, 56'h5008, 1'b1), 64'h66);
    s_ctrl_flush = MPT_FLUSH_SPEC; m_data_ready = 1; s_data_valid = 1;
    s_data_data = mk_txn(8'h22, 56'h6000, 1'b0); #1;
    chk("spec1_status", m_status_flushed, MPT_FLUSHED_COMPLETED);
    chk("spec1_no_accept", s_data_ready, 0);
    step(); s_ctrl_flush = MPT_FLUSH_NONE; m_data_ready = 0; s_data_valid = 0;
    chk("spec1_idle_valid", m_data_valid, 0);
    chk("spec1_idle_busy", m_status_busy, 0);
    chk("spec1_cleared", m_data_data, 0);
    chk("spec1_no_req", mem_req_o, 0);
    $display("seq flush_spec spec done");

    // Flush in REQ with grant in the same cycle must drain.
    s_data_valid = 1; s_data_data = mk_txn(8'h30, 56'h7000, 1'b0); step(); s_data_valid = 0;
    s_ctrl_flush = MPT_FLUSH_ALL; mem_gnt_i = 1; #1;
    chk("reqgnt_flush_status", m_status_flushed, MPT_FLUSHED_NONE);
    step(); s_ctrl_flush = MPT_FLUSH_NONE; mem_gnt_i = 0;
    chk("reqgnt_drain_req", mem_req_o, 0);
    chk("reqgnt_drain_busy", m_status_busy, 1);
    mem_rvalid_i = 1; #1;
    chk("reqgnt_completed", m_status_flushed, MPT_FLUSHED_COMPLETED);
    step(); mem_rvalid_i = 0;
    chk("reqgnt_idle", m_status_busy, 0);

    // Flush in REQ without grant cancels straight to IDLE.
    s_data_valid = 1; s_data_data = mk_txn(8'h31, 56'h7008, 1'b0); step(); s_data_valid = 0;
    s_ctrl_flush = MPT_FLUSH_ALL; #1;
    chk("req_flush_status", m_status_flushed, MPT_FLUSHED_COMPLETED);
    step(); s_ctrl_flush = MPT_FLUSH_NONE;
    chk("req_flush_idle", m_status_busy, 0);
    chk("req_flush_noreq", mem_req_o, 0);
    $display("seq flush_req done");

    // Back-to-back: OUT handshake with a new transaction goes straight to REQ.
    to_out(mk_txn(8'h40, 56'h8000, 1'b0), 64'h77);
    m_data_ready = 1; s_data_valid = 1; s_data_data = mk_txn(8'h41, 56'h8010, 1'b0); #1;
    chk("b2b_s_ready", s_data_ready, 1);
    step(); m_data_ready = 0; s_data_valid = 0;
    chk("b2b_req", mem_req_o, 1);
    chk("b2b_addr", mem_addr_o, 56'h8010);
    chk("b2b_valid_low", m_data_valid, 0);
    mem_gnt_i = 1; step(); mem_gnt_i = 0;

    // Reset mid-WAIT drops the transaction.
    rst_i = 1; step(); rst_i = 0;
    chk("rstwait_busy", m_status_busy, 0);
    chk("rstwait_data", m_data_data, 0);
    chk("rstwait_ready", s_data_ready, 1);
    $display("seq b2b and reset done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
